// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a decoded request (kind, ALU op, funct3,
// register indices, full immediate) into a 32-bit RV32I word.
// Two-stage pipeline: S1 holds the request fields and its legality bit, and
// S2 holds the encoded word. Illegal requests are emitted as NOP with o_err set.
// Delivered words are counted separately for legal and illegal results.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never depends on ready. While valid is high and ready is
// low, the payload is held stable. Ready may depend on the downstream ready,
// but it never depends on the upstream valid.
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [3:0]  i_kind,
  input  logic [3:0]  i_alu_op,
  input  logic [2:0]  i_f3,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [15:0] o_cnt_ok,
  output logic [15:0] o_cnt_err
);

  // Request kinds
  localparam logic [3:0] K_JAL    = 4'd0;
  localparam logic [3:0] K_JALR   = 4'd1;
  localparam logic [3:0] K_BRANCH = 4'd2;
  localparam logic [3:0] K_LOAD   = 4'd3;
  localparam logic [3:0] K_STORE  = 4'd4;
  localparam logic [3:0] K_OPIMM  = 4'd5;
  localparam logic [3:0] K_OP     = 4'd6;
  localparam logic [3:0] K_AUIPC  = 4'd7;
  localparam logic [3:0] K_LUI    = 4'd8;

  // ALU operations
  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLL  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_SLT  = 4'd8;
  localparam logic [3:0] A_SLTU = 4'd9;

  // Major opcodes
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [31:0] NOP = 32'h00000013;

  // Pipeline control
  logic s1_vld;
  logic s2_load;
  logic s1_adv;
  logic accept;
  logic deliver;

  // S1 registered fields
  logic [3:0]  s1_kind;
  logic [3:0]  s1_alu_op;
  logic [2:0]  s1_f3;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic        s1_illegal;

  // Legality of the incoming request
  logic req_illegal;
  logic imm_i_ok;
  logic imm_b_ok;
  logic imm_j_ok;
  logic imm_u_ok;
  logic imm_sh_ok;
  logic in_alu_bad;
  logic in_alu_shift;

  // Encoding of the S1 request
  logic [31:0] enc;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic        s1_alu_shift;

  // Stage advance: S2 takes a new word when it is empty or handing one off;
  // S1 moves forward whenever S2 can take it. Ready is held low in reset.
  always_comb begin
    deliver   = o_vld & i_rdy;
    s2_load   = ~o_vld | i_rdy;
    s1_adv    = s1_vld & s2_load;
    o_req_rdy = ~i_rst & (~s1_vld | s1_adv);
    accept    = i_req_vld & o_req_rdy;
  end

  // Legality check on the raw request, evaluated before it enters S1
  always_comb begin
    // Range checks expressed as "upper bits are a pure sign extension"
    imm_i_ok     = (i_imm[31:11] == {21{i_imm[11]}});
    imm_b_ok     = (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0];
    imm_j_ok     = (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0];
    imm_u_ok     = (i_imm[11:0] == 12'd0);
    imm_sh_ok    = (i_imm[31:5] == 27'd0);
    in_alu_bad   = (i_alu_op > A_SLTU);
    in_alu_shift = (i_alu_op == A_SLL) || (i_alu_op == A_SRL) ||
                   (i_alu_op == A_SRA);
    req_illegal  = 1'b0;
    case (i_kind)
      K_JAL:    req_illegal = !imm_j_ok;
      K_JALR:   req_illegal = !imm_i_ok;
      K_BRANCH: req_illegal = !imm_b_ok || (i_f3 == 3'b010) ||
                              (i_f3 == 3'b011);
      K_LOAD:   req_illegal = !imm_i_ok || (i_f3 == 3'b011) ||
                              (i_f3 == 3'b110) || (i_f3 == 3'b111);
      K_STORE:  req_illegal = !imm_i_ok || (i_f3 > 3'b010);
      // ALU op is only meaningful for the two ALU kinds
      K_OPIMM:  req_illegal = in_alu_bad || (i_alu_op == A_SUB) ||
                              (in_alu_shift ? !imm_sh_ok : !imm_i_ok);
      K_OP:     req_illegal = in_alu_bad;
      K_AUIPC:  req_illegal = !imm_u_ok;
      K_LUI:    req_illegal = !imm_u_ok;
      default:  req_illegal = 1'b1;
    endcase
  end

  // S1 register: capture an accepted request, empty when it moves to S2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld     <= 1'b0;
      s1_kind    <= 4'd0;
      s1_alu_op  <= 4'd0;
      s1_f3      <= 3'd0;
      s1_rd      <= 5'd0;
      s1_rs1     <= 5'd0;
      s1_rs2     <= 5'd0;
      s1_imm     <= 32'd0;
      s1_illegal <= 1'b0;
    end else if (accept) begin
      s1_vld     <= 1'b1;
      s1_kind    <= i_kind;
      s1_alu_op  <= i_alu_op;
      s1_f3      <= i_f3;
      s1_rd      <= i_rd;
      s1_rs1     <= i_rs1;
      s1_rs2     <= i_rs2;
      s1_imm     <= i_imm;
      s1_illegal <= req_illegal;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // ALU op to funct3/funct7 mapping for the request held in S1
  always_comb begin
    alu_f3       = 3'b000;
    alu_f7       = 7'b0000000;
    s1_alu_shift = 1'b0;
    case (s1_alu_op)
      A_ADD:  alu_f3 = 3'b000;
      A_SUB:  begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
      A_AND:  alu_f3 = 3'b111;
      A_OR:   alu_f3 = 3'b110;
      A_XOR:  alu_f3 = 3'b100;
      A_SLL:  begin alu_f3 = 3'b001; s1_alu_shift = 1'b1; end
      A_SRL:  begin alu_f3 = 3'b101; s1_alu_shift = 1'b1; end
      A_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; s1_alu_shift = 1'b1; end
      A_SLT:  alu_f3 = 3'b010;
      A_SLTU: alu_f3 = 3'b011;
      default: alu_f3 = 3'b000;
    endcase
  end

  // Instruction format assembly; illegal requests collapse to NOP
  always_comb begin
    enc = NOP;
    case (s1_kind)
      K_JAL:
        enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
               s1_rd, OPC_JAL};
      K_JALR:
        enc = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, OPC_JALR};
      K_BRANCH:
        enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
               s1_imm[4:1], s1_imm[11], OPC_BRANCH};
      K_LOAD:
        enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OPC_LOAD};
      K_STORE:
        enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], OPC_STORE};
      K_OPIMM:
        // Shift-immediates carry funct7 in imm[11:5] (SRAI sets bit 10)
        if (s1_alu_shift)
          enc = {alu_f7, s1_imm[4:0], s1_rs1, alu_f3, s1_rd, OPC_OPIMM};
        else
          enc = {s1_imm[11:0], s1_rs1, alu_f3, s1_rd, OPC_OPIMM};
      K_OP:
        enc = {alu_f7, s1_rs2, s1_rs1, alu_f3, s1_rd, OPC_OP};
      K_AUIPC:
        enc = {s1_imm[31:12], s1_rd, OPC_AUIPC};
      K_LUI:
        enc = {s1_imm[31:12], s1_rd, OPC_LUI};
      default:
        enc = NOP;
    endcase
    if (s1_illegal) enc = NOP;
  end

  // S2 register: output word, held while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld   <= 1'b0;
      o_instr <= 32'd0;
      o_err   <= 1'b0;
    end else if (s2_load) begin
      o_vld <= s1_vld;
      if (s1_vld) begin
        o_instr <= enc;
        o_err   <= s1_illegal;
      end
    end
  end

  // Delivery counters, wrapping modulo 2^16
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_ok  <= 16'd0;
      o_cnt_err <= 16'd0;
    end else if (deliver) begin
      if (o_err) o_cnt_err <= o_cnt_err + 16'd1;
      else       o_cnt_ok  <= o_cnt_ok + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, stall,
// mid-cycle reset and counter wrap scenarios.
module tb_instr_encoder;

  localparam logic [3:0] K_JAL = 4'd0, K_JALR = 4'd1, K_BRANCH = 4'd2,
                         K_LOAD = 4'd3, K_STORE = 4'd4, K_OPIMM = 4'd5,
                         K_OP = 4'd6, K_AUIPC = 4'd7, K_LUI = 4'd8;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6,
                         A_SRA = 4'd7;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_vld = 1'b0;
  logic        o_req_rdy;
  logic [3:0]  i_kind = 4'd0;
  logic [3:0]  i_alu_op = 4'd0;
  logic [2:0]  i_f3 = 3'd0;
  logic [4:0]  i_rd = 5'd0;
  logic [4:0]  i_rs1 = 5'd0;
  logic [4:0]  i_rs2 = 5'd0;
  logic [31:0] i_imm = 32'd0;
  logic        o_vld;
  logic        i_rdy = 1'b1;
  logic [31:0] o_instr;
  logic        o_err;
  logic [15:0] o_cnt_ok;
  logic [15:0] o_cnt_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];   // {err, instr}
  int          acc_q[$];   // cycle of acceptance
  logic [32:0] exp_in = 33'd0;
  bit          chk_lat = 1'b0;
  bit          mon_en = 1'b0;
  logic [15:0] m_ok = 16'd0;
  logic [15:0] m_err = 16'd0;

  // Clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  instr_encoder dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req_vld (i_req_vld),
    .o_req_rdy (o_req_rdy),
    .i_kind    (i_kind),
    .i_alu_op  (i_alu_op),
    .i_f3      (i_f3),
    .i_rd      (i_rd),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_imm     (i_imm),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_instr   (o_instr),
    .o_err     (o_err),
    .o_cnt_ok  (o_cnt_ok),
    .o_cnt_err (o_cnt_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: compare the head of the expected queue with the output
  // word, retire it on delivery, and record new accepts.
  always @(negedge i_clk) begin
    logic [32:0] w;
    if (mon_en && !i_rst) begin
      check("cnt_ok", o_cnt_ok, m_ok);
      check("cnt_err", o_cnt_err, m_err);
      if (o_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL stale_word got=%h exp=none at cycle %0d", o_instr, cyc);
        end else begin
          check("instr", o_instr, exp_q[0][31:0]);
          check("err", o_err, exp_q[0][32]);
          if (i_rdy) begin
            if (chk_lat) check("latency", cyc - acc_q[0], 2);
            w = exp_q.pop_front();
            void'(acc_q.pop_front());
            if (w[32]) m_err = m_err + 16'd1;
            else       m_ok  = m_ok + 16'd1;
          end
        end
      end
      if (i_req_vld && o_req_rdy) begin
        exp_q.push_back(exp_in);
        acc_q.push_back(cyc);
      end
    end
  end

  // Driver: place a request on the inputs (called just after a rising edge)
  task automatic present(input logic [3:0] k, input logic [3:0] a,
                         input logic [2:0] f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic [31:0] ei,
                         input logic ee);
    i_req_vld = 1'b1;
    i_kind    = k;
    i_alu_op  = a;
    i_f3      = f;
    i_rd      = rd;
    i_rs1     = rs1;
    i_rs2     = rs2;
    i_imm     = imm;
    exp_in    = {ee, ei};
  endtask

  // Driver: hold the request until it is accepted, bounded
  task automatic wait_accept();
    logic acc;
    for (int t = 0; t < 50; t++) begin
      @(negedge i_clk);
      acc = o_req_rdy;
      @(posedge i_clk);
      #1;
      if (acc) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL accept_timeout got=no_accept exp=accept at cycle %0d", cyc);
  endtask

  task automatic send(input logic [3:0] k, input logic [3:0] a,
                      input logic [2:0] f, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ei,
                      input logic ee);
    present(k, a, f, rd, rs1, rs2, imm, ei, ee);
    wait_accept();
  endtask

  // Driver: stop requesting and wait until every expected word is delivered
  task automatic drain();
    i_req_vld = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) return;
      @(posedge i_clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout got=%0d exp=0 words pending", exp_q.size());
  endtask

  initial begin
    // Reset values while reset is held
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_vld", o_vld, 0);
    check("rst_req_rdy", o_req_rdy, 0);
    check("rst_instr", o_instr, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt_ok", o_cnt_ok, 0);
    check("rst_cnt_err", o_cnt_err, 0);
    @(posedge i_clk);
    #2;
    i_rst  = 1'b0;
    mon_en = 1'b1;
    @(negedge i_clk);
    check("rdy_after_rst", o_req_rdy, 1);
    @(posedge i_clk);
    #1;

    // Back-to-back ALU words with 2-cycle latency
    chk_lat = 1'b1;
    send(K_OPIMM, A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    send(K_OP,    A_SUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
    send(K_OPIMM, A_SRA, 3'd0, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293, 1'b0);
    drain();
    check("t1_cnt_ok", o_cnt_ok, 3);

    // Other formats
    send(K_BRANCH, A_ADD, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0);
    send(K_JAL,    A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0);
    send(K_LUI,    A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0);
    send(K_STORE,  A_ADD, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0);
    send(K_JALR,   A_ADD, 3'd5, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF100E7, 1'b0);
    send(K_AUIPC,  A_ADD, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00001000, 32'h00001117, 1'b0);
    drain();
    check("t2_cnt_ok", o_cnt_ok, 9);
    check("t2_cnt_err", o_cnt_err, 0);

    // Illegal requests become NOP with error flag
    send(K_BRANCH, A_ADD, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7, 32'h00000013, 1'b1);
    send(K_OPIMM,  A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h00000013, 1'b1);
    send(4'd12,    A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
    drain();
    check("t3_cnt_err", o_cnt_err, 3);
    check("t3_cnt_ok", o_cnt_ok, 9);

    // Boundaries: lowest I immediate, largest shamt, funct3 rules
    send(K_OPIMM,  A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    send(K_LOAD,   A_ADD, 3'd2, 5'd5, 5'd6, 5'd0, 32'd16, 32'h01032283, 1'b0);
    send(K_OPIMM,  A_SRL, 3'd0, 5'd1, 5'd2, 5'd0, 32'd31, 32'h01F15093, 1'b0);
    send(K_OPIMM,  A_SLL, 3'd0, 5'd1, 5'd2, 5'd0, 32'd32, 32'h00000013, 1'b1);
    send(K_STORE,  A_ADD, 3'd3, 5'd0, 5'd1, 5'd2, 32'd0, 32'h00000013, 1'b1);
    send(K_OPIMM,  A_SUB, 3'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'h00000013, 1'b1);
    send(K_BRANCH, A_ADD, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00000013, 1'b1);
    send(K_LOAD,   A_ADD, 3'd3, 5'd5, 5'd6, 5'd0, 32'd16, 32'h00000013, 1'b1);
    drain();
    check("t3b_cnt_ok", o_cnt_ok, 12);
    check("t3b_cnt_err", o_cnt_err, 8);
    chk_lat = 1'b0;

    // Downstream stall: two held, third refused until release
    i_rdy = 1'b0;
    send(K_OP, A_ADD, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3, 1'b0);
    send(K_OP, A_OR,  3'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062E233, 1'b0);
    present(K_OP, A_XOR, 3'd0, 5'd7, 5'd8, 5'd9, 32'd0, 32'h009443B3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("stall_req_rdy", o_req_rdy, 0);
      check("stall_vld", o_vld, 1);
    end
    @(posedge i_clk);
    #1;
    i_rdy = 1'b1;
    wait_accept();
    drain();
    check("t4_cnt_ok", o_cnt_ok, 15);

    // Reset pulse between edges with two words in flight
    i_rdy = 1'b0;
    send(K_OPIMM, A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    send(K_OPIMM, A_ADD, 3'd0, 5'd2, 5'd0, 5'd0, 32'd5, 32'h00500113, 1'b0);
    i_req_vld = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    check("mid_rst_vld", o_vld, 0);
    check("mid_rst_req_rdy", o_req_rdy, 0);
    check("mid_rst_instr", o_instr, 0);
    check("mid_rst_err", o_err, 0);
    check("mid_rst_cnt_ok", o_cnt_ok, 0);
    check("mid_rst_cnt_err", o_cnt_err, 0);
    exp_q.delete();
    acc_q.delete();
    m_ok  = 16'd0;
    m_err = 16'd0;
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    i_rdy = 1'b1;
    @(negedge i_clk);
    check("post_rst_req_rdy", o_req_rdy, 1);
    repeat (4) @(negedge i_clk);
    check("post_rst_vld", o_vld, 0);
    @(posedge i_clk);
    #1;

    // Counter wrap
    for (int i = 0; i < 65535; i++)
      send(K_OPIMM, A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    drain();
    check("wrap_pre_cnt_ok", o_cnt_ok, 32'h0000FFFF);
    send(K_OPIMM, A_ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    drain();
    check("wrap_cnt_ok", o_cnt_ok, 0);
    check("wrap_cnt_err", o_cnt_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
